// File: rtl/contador_descendente_pkg.sv
// Shared types and defaults for the loadable down-counter and its prescaler.
// The optional auto-reload mode is selected with CONTADOR_AUTORECARGA_EN.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } estado_t;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned PRESCALE_DEF = 1;

endpackage

// File: rtl/contador_descendente_if.sv
// Control/status bundle of the down-counter: the requester drives the master side,
// the counter sits on the slave side.
interface contador_descendente_if
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             iStart;
    logic [WIDTH-1:0] iCarga;
    logic             iPausa;
    logic             iParo;
    logic [WIDTH-1:0] oCuenta;
    logic             oOcupado;
    logic             oFin;

    modport master (
        output iStart, iCarga, iPausa, iParo,
        input  oCuenta, oOcupado, oFin
    );

    modport slave (
        input  iStart, iCarga, iPausa, iParo,
        output oCuenta, oOcupado, oFin
    );

endinterface

// File: rtl/contador_descendente_divisor_tick.sv
// Clock prescaler: counts 0..PRESCALE-1 while enabled and flags the wrapping cycle.
// Kept standalone so the up counter can share it.
module divisor_tick
    import contador_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic iClk,
    input  logic iRst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  ULTIMO = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == ULTIMO);

    always_ff @(posedge iClk) begin
        if (iRst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == ULTIMO) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/contador_descendente.sv
// Loadable down-counter / countdown timer with one-cycle done pulse.
// Define CONTADOR_AUTORECARGA_EN to make the count repeat from the loaded value.
module contador_descendente
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic                   iClk,
    input  logic                   iRst,
    contador_descendente_if.slave  bus
);

    estado_t          estado;
    logic [WIDTH-1:0] cuenta;
    logic             ocupado;
    logic             fin;
    logic             tick;
    logic             acepta;
    logic             en_div;
    logic             clr_div;

    // Loads are taken from IDLE and FIN alike so runs can be chained.
    assign acepta  = bus.iStart && !bus.iParo && (estado != RUN);
    assign en_div  = (estado == RUN) && !bus.iPausa && !bus.iParo;
    assign clr_div = (estado != RUN) || bus.iParo;

    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor (
        .iClk   (iClk),
        .iRst   (iRst),
        .clear  (clr_div),
        .enable (en_div),
        .tick   (tick)
    );

`ifdef CONTADOR_AUTORECARGA_EN
    logic [WIDTH-1:0] recarga;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            recarga <= '0;
        end else if (acepta) begin
            recarga <= bus.iCarga;
        end
    end
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            estado  <= IDLE;
            cuenta  <= '0;
            ocupado <= 1'b0;
            fin     <= 1'b0;
        end else if (bus.iParo) begin
            if (estado != IDLE) begin
                cuenta <= '0;
            end
            estado  <= IDLE;
            ocupado <= 1'b0;
            fin     <= 1'b0;
        end else if (acepta) begin
            cuenta <= bus.iCarga;
            if (bus.iCarga == '0) begin
                estado  <= FIN;
                ocupado <= 1'b0;
                fin     <= 1'b1;
            end else begin
                estado  <= RUN;
                ocupado <= 1'b1;
                fin     <= 1'b0;
            end
        end else begin
            fin <= 1'b0;
            case (estado)
                RUN: begin
                    if (tick) begin
                        if (cuenta == WIDTH'(1)) begin
`ifdef CONTADOR_AUTORECARGA_EN
                            cuenta <= recarga;
                            fin    <= 1'b1;
`else
                            cuenta  <= '0;
                            estado  <= FIN;
                            ocupado <= 1'b0;
                            fin     <= 1'b1;
`endif
                        end else begin
                            cuenta <= cuenta - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oCuenta  = cuenta;
    assign bus.oOcupado = ocupado;
    assign bus.oFin     = fin;

endmodule

// File: doc/contador_descendente.md
Name: contador_descendente

Overview:
- Loadable down-counter / countdown timer; the decrementing counterpart of the team's free-running 4-bit up counter.
- Loads a start value on a request and decrements once per prescaled tick.
- Pulses a one-cycle done flag at terminal count, then returns to idle.
- Drives delays and timeouts for blocks that currently count up and compare.

Parameters:
- WIDTH, 4, width of the count and load value.
- PRESCALE, 1, clock cycles per decrement tick. Legal range ≥1; 1 means a decrement every cycle.

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  load-and-run request; sampled on each rising edge.
- iCarga  input  WIDTH  start value; captured when iStart is accepted.
- iPausa  input  1  holds count and prescaler while high.
- iParo  input  1  abort; returns the block to idle.
- oCuenta  output  WIDTH  current count.
- oOcupado  output  1  high while in RUN.
- oFin  output  1  one-cycle pulse at terminal count.

Behaviour:
- Reset: synchronous, active-high on iRst; applies on the next edge, including mid-count.
  - oCuenta=0, oOcupado=0, oFin=0.
  - State IDLE; prescaler=0; reload register=0.
- States: IDLE, RUN, FIN.
- Outputs per state:
  - oOcupado=1 only in RUN.
  - oFin=1 only in FIN.
  - oCuenta is registered; it holds its last value in IDLE.
- IDLE:
  - iStart=1 with iCarga≠0 at edge N: oCuenta=iCarga, reload register=iCarga, prescaler cleared, state RUN, all visible after edge N.
  - iStart=1 with iCarga=0: oCuenta=0, state FIN (oFin high for one cycle); RUN is never entered.
- Prescaler tick:
  - Prescaler counts 0..PRESCALE-1 while in RUN and iPausa=0.
  - A tick occurs on the edge where prescaler==PRESCALE-1; the prescaler then wraps to 0.
- RUN:
  - On a tick, oCuenta decrements by 1.
  - The tick taking oCuenta 1→0 moves state to FIN.
  - With PRESCALE=1 and start accepted at edge N: oCuenta=0 and oFin=1 after edge N+L, oFin=0 and state IDLE after edge N+L+1.
- FIN: lasts exactly one cycle, then IDLE. An iStart sampled in FIN is accepted as in IDLE, allowing back-to-back runs.
- iStart in RUN: ignored.
- iPausa:
  - Effective only in RUN; freezes oCuenta and the prescaler.
  - iPausa and iStart together in IDLE: the load still happens, and the pause applies from the first RUN cycle.
- iParo in RUN or FIN: next state IDLE, oCuenta=0, oFin=0, no done pulse.
- Priority: iRst > iParo > iStart > iPausa.
- Arithmetic: unsigned WIDTH bits. Underflow is impossible because 0 is never decremented.

Optional Feature:
- Macro: CONTADOR_AUTORECARGA_EN.
- Defined:
  - In RUN, the tick at oCuenta==1 reloads oCuenta from the reload register instead of writing 0.
  - oFin pulses in the following cycle; the block stays in RUN and oOcupado stays 1.
  - Count sequence is L..1, repeating with a period of L ticks.
  - Only iParo or iRst stop it.
  - A load of 0 still goes to FIN once and does not auto-repeat.
- Undefined: single-shot behaviour as specified above.

Decomposition:
- Package contador_pkg:
  - State typedef: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - Default WIDTH and PRESCALE constants.
- Sub-module divisor_tick, parameter PRESCALE:
  - Inputs: iClk, iRst, clear, enable.
  - Output: one-cycle tick.
  - Reusable by the up counter.

Test Plan:
- Reset then iStart=1, iCarga=4'd3 (PRESCALE=1) -> oCuenta 3,2,1,0 on consecutive cycles; oFin=1 exactly in the cycle oCuenta=0; oOcupado=1 for 3 cycles; then IDLE.
- iCarga=0 with iStart -> no RUN; oFin one-cycle pulse in the cycle after start; oCuenta=0.
- iCarga=5, iPausa high for 4 cycles mid-run -> oCuenta frozen during the pause; total start-to-oFin latency 5+4 cycles.
- PRESCALE=3, iCarga=2 -> decrements every 3rd cycle; oFin 6 cycles after the start edge.
- iParo (and separately iRst) asserted at oCuenta=2 -> oCuenta=0, oFin never pulses; iStart during RUN is ignored.
- With CONTADOR_AUTORECARGA_EN, iCarga=2 -> oCuenta 2,1,2,1,...; oFin pulses every 2 cycles until iParo.
